step3_control_fsm: RTL and testbench

- Multicycle control unit and PC owner for the 16-bit step3 datapath (register file, ALU, immediate generator, unified memory, MDR).
- Drives every datapath control line from Op and ALU feedback, and sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
- Holds the program counter and presents it to the datapath's PC input.

---
 rtl/step3_control_fsm.sv | 180 ++++++++++++++++++
 tb/tb_step3_control_fsm.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/step3_control_fsm.sv
// Multicycle control unit and PC owner for the 16-bit step3 datapath.
// Optional STEP3_CTRL_PERF_EN adds saturating cycle/instruction counters.
module step3_control_fsm #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        run,
  input  logic [3:0]  Op,
  input  logic [15:0] ALUOut,
  input  logic [15:0] A,
  output logic [2:0]  ALUOp,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic        writeEnable,
  output logic [1:0]  immShift,
  output logic [1:0]  numBits,
  output logic        IRWrite,
  output logic        memEnableRead,
  output logic        memEnableWrite,
  output logic        memAddrSel,
  output logic [2:0]  regDataWrite,
  output logic [15:0] PC,
  output logic        halted,
  output logic [2:0]  state
`ifdef STEP3_CTRL_PERF_EN
  ,
  output logic [31:0] cycleCount,
  output logic [31:0] instrCount
`endif
);

  // state  | meaning
  // IDLE   | waiting for run
  // FETCH  | IR <= mem[PC], PC += PC_STEP
  // DECODE | ALU computes PC+imm into target
  // EXEC   | opcode-specific ALU op, branches/jumps resolve
  // MEM    | load or store at ALUOut
  // WB     | register-file write
  // HALT   | stopped until reset
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
  } state_t;

  typedef struct packed {
    logic [2:0] aluop;
    logic       srca;
    logic       srcb;
    logic       we;
    logic [1:0] imms;
    logic [1:0] nbits;
    logic       irw;
    logic       mrd;
    logic       mwr;
    logic       masel;
    logic [2:0] rdw;
    logic       hlt;
  } ctrl_t;

  state_t      cur, nxt;
  ctrl_t       ctl, nxt_ctl;
  logic [15:0] target;
  logic        take_branch;

  // Moore outputs are registered, so they are derived from the state being entered.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  c.irw = 1'b1;
      S_DECODE: c.srcb = 1'b1;
      S_EXEC: begin
        case (op)
          4'd0, 4'd1, 4'd2, 4'd3: begin c.srca = 1'b1; c.aluop = op[2:0]; end
          4'd4, 4'd6, 4'd7:       begin c.srca = 1'b1; c.srcb = 1'b1; end
          4'd5:                   begin c.imms = 2'd1; c.nbits = 2'd2; end
          4'd13:                  c.nbits = 2'd1;
          4'd8, 4'd9, 4'd12:      begin c.srca = 1'b1; c.aluop = 3'd1; end
          4'd10:                  begin c.rdw = 3'd2; c.we = 1'b1; end
          default: ;
        endcase
      end
      S_MEM: begin
        c.masel = 1'b1;
        c.srca  = 1'b1;
        c.srcb  = 1'b1;
        c.mrd   = (op == 4'd6);
        c.mwr   = (op == 4'd7);
      end
      S_WB: begin
        c.we = 1'b1;
        case (op)
          4'd5, 4'd13: c.rdw = 3'd3;
          4'd6:        c.rdw = 3'd1;
          4'd12:       c.rdw = 3'd4;
          default:     c.rdw = 3'd0;
        endcase
      end
      S_HALT:  c.hlt = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   nxt = run ? S_FETCH : S_IDLE;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        if (Op == 4'd15)      nxt = S_HALT;
        else if (Op == 4'd14) nxt = S_FETCH;
        else                  nxt = S_EXEC;
      end
      S_EXEC: begin
        case (Op)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13: nxt = S_WB;
          4'd6, 4'd7: nxt = S_MEM;
          default:    nxt = S_FETCH;
        endcase
      end
      S_MEM:   nxt = (Op == 4'd6) ? S_WB : S_FETCH;
      S_WB:    nxt = S_FETCH;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
    nxt_ctl = ctrl_for(nxt, Op);
  end

  assign take_branch = (ALUOut == 16'h0000) ^ Op[0];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cur    <= S_IDLE;
      ctl    <= '0;
      PC     <= RESET_PC;
      target <= 16'h0000;
`ifdef STEP3_CTRL_PERF_EN
      cycleCount <= 32'd0;
      instrCount <= 32'd0;
`endif
    end else begin
      cur <= nxt;
      ctl <= nxt_ctl;
      if (cur == S_FETCH) PC <= PC + PC_STEP;
      if (cur == S_DECODE) target <= ALUOut;
      if (cur == S_EXEC) begin
        case (Op)
          4'd8, 4'd9: if (take_branch) PC <= target;
          4'd10:      PC <= target;
          4'd11:      PC <= A;
          default: ;
        endcase
      end
`ifdef STEP3_CTRL_PERF_EN
      if (cur != S_IDLE && cur != S_HALT && cycleCount != 32'hFFFF_FFFF)
        cycleCount <= cycleCount + 32'd1;
      if (cur == S_DECODE && instrCount != 32'hFFFF_FFFF)
        instrCount <= instrCount + 32'd1;
`endif
    end
  end

  assign ALUOp          = ctl.aluop;
  assign ALUSrcA        = ctl.srca;
  assign ALUSrcB        = ctl.srcb;
  assign writeEnable    = ctl.we;
  assign immShift       = ctl.imms;
  assign numBits        = ctl.nbits;
  assign IRWrite        = ctl.irw;
  assign memEnableRead  = ctl.mrd;
  assign memEnableWrite = ctl.mwr;
  assign memAddrSel     = ctl.masel;
  assign regDataWrite   = ctl.rdw;
  assign halted         = ctl.hlt;
  assign state          = cur;

endmodule

// File: tb/tb_step3_control_fsm.sv
// Scoreboard bench for step3_control_fsm: per-cycle expected state/controls/PC.
module tb_step3_control_fsm;

  logic        CLK, reset, run;
  logic [3:0]  Op;
  logic [15:0] ALUOut, A;
  logic [2:0]  ALUOp, regDataWrite, state;
  logic        ALUSrcA, ALUSrcB, writeEnable, IRWrite;
  logic        memEnableRead, memEnableWrite, memAddrSel, halted;
  logic [1:0]  immShift, numBits;
  logic [15:0] PC;
`ifdef STEP3_CTRL_PERF_EN
  logic [31:0] cycleCount, instrCount;
`endif

  step3_control_fsm dut (
    .CLK(CLK), .reset(reset), .run(run), .Op(Op), .ALUOut(ALUOut), .A(A),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .writeEnable(writeEnable), .immShift(immShift), .numBits(numBits),
    .IRWrite(IRWrite), .memEnableRead(memEnableRead),
    .memEnableWrite(memEnableWrite), .memAddrSel(memAddrSel),
    .regDataWrite(regDataWrite), .PC(PC), .halted(halted), .state(state)
`ifdef STEP3_CTRL_PERF_EN
    , .cycleCount(cycleCount), .instrCount(instrCount)
`endif
  );

  typedef struct {
    string       nm;
    logic [2:0]  st;
    logic [17:0] c;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event sample_ev;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                         MEM = 3'd4, WB = 3'd5, HALT = 3'd6;

  logic [17:0] NONE, FET, DEC, EX_ALU, WB_ALU, EX_MEM, MEM_LW, WB_LW, EX_BR, HLT, MEM_SW;

  function automatic logic [17:0] mk(input logic [2:0] aluop, input logic sa, input logic sb_,
                                     input logic we, input logic [1:0] ims, input logic [1:0] nb,
                                     input logic irw, input logic mrd, input logic mwr,
                                     input logic masel, input logic [2:0] rdw, input logic hl);
    return {aluop, sa, sb_, we, ims, nb, irw, mrd, mwr, masel, rdw, hl};
  endfunction

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Monitor: compare outputs against the oldest expectation on each sample point.
  initial begin
    exp_t e;
    logic [17:0] obs;
    forever begin
      @(negedge CLK or sample_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        obs = {ALUOp, ALUSrcA, ALUSrcB, writeEnable, immShift, numBits, IRWrite,
               memEnableRead, memEnableWrite, memAddrSel, regDataWrite, halted};
        checks++;
        if (state !== e.st || obs !== e.c || PC !== e.pc) begin
          errors++;
          $display("FAIL %s: got state=%0d ctl=%h pc=%h, required state=%0d ctl=%h pc=%h",
                   e.nm, state, obs, PC, e.st, e.c, e.pc);
        end
      end
    end
  end

  task automatic step(input string nm, input logic [3:0] op, input logic [15:0] alu,
                      input logic [15:0] a, input logic [2:0] st, input logic [17:0] c,
                      input logic [15:0] pc);
    exp_t e;
    @(posedge CLK);
    #2;
    Op = op; ALUOut = alu; A = a;
    e.nm = nm; e.st = st; e.c = c; e.pc = pc;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    NONE   = '0;
    FET    = mk(3'd0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 0, 0, 3'd0, 0);
    DEC    = mk(3'd0, 0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 3'd0, 0);
    EX_ALU = mk(3'd0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 3'd0, 0);
    WB_ALU = mk(3'd0, 0, 0, 1, 2'd0, 2'd0, 0, 0, 0, 0, 3'd0, 0);
    EX_MEM = mk(3'd0, 1, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 3'd0, 0);
    MEM_LW = mk(3'd0, 1, 1, 0, 2'd0, 2'd0, 0, 1, 0, 1, 3'd0, 0);
    WB_LW  = mk(3'd0, 0, 0, 1, 2'd0, 2'd0, 0, 0, 0, 0, 3'd1, 0);
    EX_BR  = mk(3'd1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 3'd0, 0);
    HLT    = mk(3'd0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 3'd0, 1);
    MEM_SW = mk(3'd0, 1, 1, 0, 2'd0, 2'd0, 0, 0, 1, 1, 3'd0, 0);

    reset = 1'b1; run = 1'b0; Op = 4'd0; ALUOut = 16'h0; A = 16'h0;
    step("rst0", 4'd0, 16'h0, 16'h0, IDLE, NONE, 16'h0000);
    step("rst1", 4'd0, 16'h0, 16'h0, IDLE, NONE, 16'h0000);
    reset = 1'b0;
    step("idle_run0", 4'd0, 16'h0, 16'h0, IDLE, NONE, 16'h0000);
    run = 1'b1;

    // ADD
    step("add_fetch",  4'd0, 16'h0000, 16'h0, FETCH,  FET,    16'h0000);
    step("add_decode", 4'd0, 16'h0010, 16'h0, DECODE, DEC,    16'h0002);
    step("add_exec",   4'd0, 16'h1234, 16'h0, EXEC,   EX_ALU, 16'h0002);
    step("add_wb",     4'd0, 16'h1234, 16'h0, WB,     WB_ALU, 16'h0002);
    // LW
    step("lw_fetch",   4'd6, 16'h0000, 16'h0, FETCH,  FET,    16'h0002);
    step("lw_decode",  4'd6, 16'h0100, 16'h0, DECODE, DEC,    16'h0004);
    step("lw_exec",    4'd6, 16'h0040, 16'h0, EXEC,   EX_MEM, 16'h0004);
    step("lw_mem",     4'd6, 16'h0040, 16'h0, MEM,    MEM_LW, 16'h0004);
    step("lw_wb",      4'd6, 16'h0040, 16'h0, WB,     WB_LW,  16'h0004);
    // BEQ taken
    step("beq_t_fetch",  4'd8, 16'h0000, 16'h0, FETCH,  FET,   16'h0004);
    step("beq_t_decode", 4'd8, 16'h0020, 16'h0, DECODE, DEC,   16'h0006);
    step("beq_t_exec",   4'd8, 16'h0000, 16'h0, EXEC,   EX_BR, 16'h0006);
    // BEQ not taken
    step("beq_n_fetch",  4'd8, 16'h0000, 16'h0, FETCH,  FET,   16'h0020);
    step("beq_n_decode", 4'd8, 16'h0080, 16'h0, DECODE, DEC,   16'h0022);
    step("beq_n_exec",   4'd8, 16'h0001, 16'h0, EXEC,   EX_BR, 16'h0022);
    // JR to the top of memory
    step("jr_fetch",   4'd11, 16'h0000, 16'h0,    FETCH,  FET,  16'h0022);
    step("jr_decode",  4'd11, 16'h0000, 16'h0,    DECODE, DEC,  16'h0024);
    step("jr_exec",    4'd11, 16'h0000, 16'hFFFE, EXEC,   NONE, 16'h0024);
    // NOP at 0xFFFE: PC wraps to 0
    step("nop_fetch",  4'd14, 16'h0000, 16'h0, FETCH,  FET, 16'hFFFE);
    step("nop_decode", 4'd14, 16'h0000, 16'h0, DECODE, DEC, 16'h0000);
    // HALT
    step("hlt_fetch",  4'd15, 16'h0000, 16'h0, FETCH,  FET, 16'h0000);
    step("hlt_decode", 4'd15, 16'h0000, 16'h0, DECODE, DEC, 16'h0002);
    step("hlt_0",      4'd15, 16'h0000, 16'h0, HALT,   HLT, 16'h0002);
`ifdef STEP3_CTRL_PERF_EN
    checks++;
    if (cycleCount !== 32'd22) begin
      errors++;
      $display("FAIL perf_cycles: got %0d, required 22", cycleCount);
    end
    checks++;
    if (instrCount !== 32'd7) begin
      errors++;
      $display("FAIL perf_instr: got %0d, required 7", instrCount);
    end
`endif
    run = 1'b0;
    step("hlt_run0",   4'd0, 16'h0000, 16'h0, HALT, HLT, 16'h0002);
    run = 1'b1;
    step("hlt_run1",   4'd0, 16'h0000, 16'h0, HALT, HLT, 16'h0002);
    @(negedge CLK);
    #1 reset = 1'b1; run = 1'b0;
    step("rst2", 4'd0, 16'h0000, 16'h0, IDLE, NONE, 16'h0000);
    reset = 1'b0; run = 1'b1;
    // SW interrupted by reset in MEM
    step("sw_fetch",  4'd7, 16'h0000, 16'h0, FETCH,  FET,    16'h0000);
    step("sw_decode", 4'd7, 16'h0300, 16'h0, DECODE, DEC,    16'h0002);
    step("sw_exec",   4'd7, 16'h0050, 16'h0, EXEC,   EX_MEM, 16'h0002);
    step("sw_mem",    4'd7, 16'h0050, 16'h0, MEM,    MEM_SW, 16'h0002);
    run = 1'b0;
    @(negedge CLK);
    #1 reset = 1'b1;
    #2;
    e.nm = "sw_async_rst"; e.st = IDLE; e.c = NONE; e.pc = 16'h0000;
    sb.push_back(e);
    -> sample_ev;
    #1 reset = 1'b0;
    step("post_rst_idle0", 4'd7, 16'h0000, 16'h0, IDLE, NONE, 16'h0000);
    step("post_rst_idle1", 4'd7, 16'h0000, 16'h0, IDLE, NONE, 16'h0000);

    repeat (3) @(negedge CLK);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
